// File: rtl/sort_e2_merge.sv
// sort_e2_merge: folds two pre-sorted 5-entry E1 lists per line into a running
// frame-wide top-5, one candidate per cycle, and publishes it at end of frame.
//
// Ports:
//   sys_clk, sys_rst      clock, asynchronous active-high reset
//   sorter_clr            synchronous clear, overrides everything else
//   E1L/E1H_sorter_out0..4 {local idx, score} candidates, each list descending
//   E1_sort_en            one-cycle strobe, candidates valid in that cycle
//   E1_last_sort          marks the final line of the frame (with E1_sort_en)
//   E1_index_counter      1-based line number of the strobed batch
//   topk_out0..4          {global idx, score} running list, descending
//   topk_cnt              number of valid entries in the running list
//   topk_valid            one-cycle strobe, list is the final frame result
//   busy                  merge FSM not idle
//   overflow              sticky, a batch arrived with the pending slot full
module sort_e2_merge #(
  parameter int unsigned Data_Width  = 8,
  parameter int unsigned Index_Width = 16,
  parameter int unsigned Lane_Bits   = 5
) (
  input  logic                                     sys_clk,
  input  logic                                     sys_rst,
  input  logic                                     sorter_clr,
  input  logic [Index_Width+Data_Width-1:0]        E1L_sorter_out0,
  input  logic [Index_Width+Data_Width-1:0]        E1L_sorter_out1,
  input  logic [Index_Width+Data_Width-1:0]        E1L_sorter_out2,
  input  logic [Index_Width+Data_Width-1:0]        E1L_sorter_out3,
  input  logic [Index_Width+Data_Width-1:0]        E1L_sorter_out4,
  input  logic [Index_Width+Data_Width-1:0]        E1H_sorter_out0,
  input  logic [Index_Width+Data_Width-1:0]        E1H_sorter_out1,
  input  logic [Index_Width+Data_Width-1:0]        E1H_sorter_out2,
  input  logic [Index_Width+Data_Width-1:0]        E1H_sorter_out3,
  input  logic [Index_Width+Data_Width-1:0]        E1H_sorter_out4,
  input  logic                                     E1_sort_en,
  input  logic                                     E1_last_sort,
  input  logic [Index_Width-1:0]                   E1_index_counter,
  output logic [Index_Width+Lane_Bits+Data_Width-1:0] topk_out0,
  output logic [Index_Width+Lane_Bits+Data_Width-1:0] topk_out1,
  output logic [Index_Width+Lane_Bits+Data_Width-1:0] topk_out2,
  output logic [Index_Width+Lane_Bits+Data_Width-1:0] topk_out3,
  output logic [Index_Width+Lane_Bits+Data_Width-1:0] topk_out4,
  output logic [2:0]                               topk_cnt,
  output logic                                     topk_valid,
  output logic                                     busy,
  output logic                                     overflow
);

  localparam int unsigned IN_W   = Index_Width + Data_Width;
  localparam int unsigned CAND_W = Lane_Bits + Data_Width;
  localparam int unsigned OUT_W  = Index_Width + Lane_Bits + Data_Width;
  localparam int          NUM_CAND = 10;
  localparam int          TOPK     = 5;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_MERGE = 2'd1;
  localparam logic [1:0] ST_EMIT  = 2'd2;

  // Most negative score marks an unused (padding) candidate.
  localparam logic [Data_Width-1:0] PAD_SCORE = {1'b1, {(Data_Width-1){1'b0}}};

  logic [1:0]             state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic                   pend_full_q, pend_full_d;
  logic                   pend_last_q, pend_last_d;
  logic [Index_Width-1:0] pend_line_q, pend_line_d;
  logic [CAND_W-1:0]      pend_cand_q [NUM_CAND];
  logic [CAND_W-1:0]      pend_cand_d [NUM_CAND];
  logic                   work_last_q, work_last_d;
  logic [Index_Width-1:0] work_line_q, work_line_d;
  logic [CAND_W-1:0]      work_cand_q [NUM_CAND];
  logic [CAND_W-1:0]      work_cand_d [NUM_CAND];
  logic [OUT_W-1:0]       list_q [TOPK];
  logic [OUT_W-1:0]       list_d [TOPK];
  logic [2:0]             topk_cnt_q, topk_cnt_d;
  logic                   overflow_q, overflow_d;

  logic [CAND_W-1:0]      in_cand [NUM_CAND];
  logic [CAND_W-1:0]      cur_cand;
  logic [Data_Width-1:0]  cur_score;
  logic [OUT_W-1:0]       cur_entry;
  logic                   is_pad;
  logic                   placed;
  logic [OUT_W-1:0]       carry;
  logic [OUT_W-1:0]       ins_list [TOPK];
  logic [2:0]             ins_cnt;
  logic                   take_pend;
  logic                   unused_hi_bits;

  // Keep only the lane bits of the local index; interleave L/H in merge order.
  always_comb begin
    in_cand[0] = {E1L_sorter_out0[Data_Width +: Lane_Bits], E1L_sorter_out0[Data_Width-1:0]};
    in_cand[1] = {E1H_sorter_out0[Data_Width +: Lane_Bits], E1H_sorter_out0[Data_Width-1:0]};
    in_cand[2] = {E1L_sorter_out1[Data_Width +: Lane_Bits], E1L_sorter_out1[Data_Width-1:0]};
    in_cand[3] = {E1H_sorter_out1[Data_Width +: Lane_Bits], E1H_sorter_out1[Data_Width-1:0]};
    in_cand[4] = {E1L_sorter_out2[Data_Width +: Lane_Bits], E1L_sorter_out2[Data_Width-1:0]};
    in_cand[5] = {E1H_sorter_out2[Data_Width +: Lane_Bits], E1H_sorter_out2[Data_Width-1:0]};
    in_cand[6] = {E1L_sorter_out3[Data_Width +: Lane_Bits], E1L_sorter_out3[Data_Width-1:0]};
    in_cand[7] = {E1H_sorter_out3[Data_Width +: Lane_Bits], E1H_sorter_out3[Data_Width-1:0]};
    in_cand[8] = {E1L_sorter_out4[Data_Width +: Lane_Bits], E1L_sorter_out4[Data_Width-1:0]};
    in_cand[9] = {E1H_sorter_out4[Data_Width +: Lane_Bits], E1H_sorter_out4[Data_Width-1:0]};
  end

  assign unused_hi_bits = ^{E1L_sorter_out0[IN_W-1:Data_Width+Lane_Bits],
                            E1L_sorter_out1[IN_W-1:Data_Width+Lane_Bits],
                            E1L_sorter_out2[IN_W-1:Data_Width+Lane_Bits],
                            E1L_sorter_out3[IN_W-1:Data_Width+Lane_Bits],
                            E1L_sorter_out4[IN_W-1:Data_Width+Lane_Bits],
                            E1H_sorter_out0[IN_W-1:Data_Width+Lane_Bits],
                            E1H_sorter_out1[IN_W-1:Data_Width+Lane_Bits],
                            E1H_sorter_out2[IN_W-1:Data_Width+Lane_Bits],
                            E1H_sorter_out3[IN_W-1:Data_Width+Lane_Bits],
                            E1H_sorter_out4[IN_W-1:Data_Width+Lane_Bits]};

  // Insertion of the current candidate into the running list. The first slot
  // that is empty or strictly beaten takes the candidate; later slots shift.
  always_comb begin
    cur_cand  = work_cand_q[cnt_q];
    cur_score = cur_cand[Data_Width-1:0];
    cur_entry = {work_line_q, cur_cand};
    is_pad    = (cur_score == PAD_SCORE);
    placed    = 1'b0;
    carry     = '0;
    for (int i = 0; i < TOPK; i++) begin
      ins_list[i] = list_q[i];
      if (placed) begin
        ins_list[i] = carry;
        carry       = list_q[i];
      end else if (!is_pad && ((3'(i) >= topk_cnt_q) ||
                   ($signed(cur_score) > $signed(list_q[i][Data_Width-1:0])))) begin
        ins_list[i] = cur_entry;
        carry       = list_q[i];
        placed      = 1'b1;
      end
    end
    ins_cnt = topk_cnt_q;
    if (placed && (topk_cnt_q != 3'd5)) begin
      ins_cnt = topk_cnt_q + 3'd1;
    end
  end

  // Next-state: merge FSM, pending/working buffer handoff, capture, clear.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pend_full_d = pend_full_q;
    pend_last_d = pend_last_q;
    pend_line_d = pend_line_q;
    pend_cand_d = pend_cand_q;
    work_last_d = work_last_q;
    work_line_d = work_line_q;
    work_cand_d = work_cand_q;
    list_d      = list_q;
    topk_cnt_d  = topk_cnt_q;
    overflow_d  = overflow_q;
    take_pend   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (pend_full_q) begin
          state_d   = ST_MERGE;
          cnt_d     = 4'd0;
          take_pend = 1'b1;
        end
      end
      ST_MERGE: begin
        list_d     = ins_list;
        topk_cnt_d = ins_cnt;
        if (cnt_q == 4'd9) begin
          cnt_d = 4'd0;
          if (work_last_q) begin
            state_d = ST_EMIT;
          end else if (pend_full_q) begin
            state_d   = ST_MERGE;
            take_pend = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_EMIT: begin
        for (int i = 0; i < TOPK; i++) begin
          list_d[i] = '0;
        end
        topk_cnt_d = 3'd0;
        if (pend_full_q) begin
          state_d   = ST_MERGE;
          cnt_d     = 4'd0;
          take_pend = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
      end
    endcase

    if (take_pend) begin
      work_last_d = pend_last_q;
      work_line_d = pend_line_q;
      work_cand_d = pend_cand_q;
      pend_full_d = 1'b0;
    end

    // A slot freed on this edge can be refilled on the same edge.
    if (E1_sort_en) begin
      if (pend_full_d) begin
        overflow_d = 1'b1;
      end else begin
        pend_full_d = 1'b1;
        pend_last_d = E1_last_sort;
        pend_line_d = E1_index_counter - Index_Width'(1);
        pend_cand_d = in_cand;
      end
    end

    if (sorter_clr) begin
      state_d     = ST_IDLE;
      cnt_d       = 4'd0;
      pend_full_d = 1'b0;
      pend_last_d = 1'b0;
      pend_line_d = '0;
      work_last_d = 1'b0;
      work_line_d = '0;
      for (int i = 0; i < NUM_CAND; i++) begin
        pend_cand_d[i] = '0;
        work_cand_d[i] = '0;
      end
      for (int i = 0; i < TOPK; i++) begin
        list_d[i] = '0;
      end
      topk_cnt_d = 3'd0;
      overflow_d = 1'b0;
    end
  end

  // State registers.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      pend_full_q <= 1'b0;
      pend_last_q <= 1'b0;
      pend_line_q <= '0;
      work_last_q <= 1'b0;
      work_line_q <= '0;
      for (int i = 0; i < NUM_CAND; i++) begin
        pend_cand_q[i] <= '0;
        work_cand_q[i] <= '0;
      end
      for (int i = 0; i < TOPK; i++) begin
        list_q[i] <= '0;
      end
      topk_cnt_q <= 3'd0;
      overflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pend_full_q <= pend_full_d;
      pend_last_q <= pend_last_d;
      pend_line_q <= pend_line_d;
      work_last_q <= work_last_d;
      work_line_q <= work_line_d;
      pend_cand_q <= pend_cand_d;
      work_cand_q <= work_cand_d;
      list_q      <= list_d;
      topk_cnt_q  <= topk_cnt_d;
      overflow_q  <= overflow_d;
    end
  end

  assign topk_out0  = list_q[0];
  assign topk_out1  = list_q[1];
  assign topk_out2  = list_q[2];
  assign topk_out3  = list_q[3];
  assign topk_out4  = list_q[4];
  assign topk_cnt   = topk_cnt_q;
  assign topk_valid = (state_q == ST_EMIT);
  assign busy       = (state_q != ST_IDLE);
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_sort_e2_merge.sv
// tb_sort_e2_merge: directed self-checking bench for sort_e2_merge.
module tb_sort_e2_merge;

  localparam int IN_W  = 24;
  localparam int OUT_W = 29;

  logic              sys_clk = 1'b0;
  logic              sys_rst;
  logic              sorter_clr;
  logic [IN_W-1:0]   l_in [5];
  logic [IN_W-1:0]   h_in [5];
  logic              en;
  logic              last;
  logic [15:0]       counter;
  logic [OUT_W-1:0]  out [5];
  logic [2:0]        topk_cnt;
  logic              topk_valid;
  logic              busy;
  logic              overflow;

  int                n_checks = 0;
  int                n_err    = 0;
  int                vcount;
  bit                busy_seen;
  logic [OUT_W-1:0]  snap [5];
  logic [2:0]        snapcnt;

  sort_e2_merge dut (
    .sys_clk          (sys_clk),
    .sys_rst          (sys_rst),
    .sorter_clr       (sorter_clr),
    .E1L_sorter_out0  (l_in[0]),
    .E1L_sorter_out1  (l_in[1]),
    .E1L_sorter_out2  (l_in[2]),
    .E1L_sorter_out3  (l_in[3]),
    .E1L_sorter_out4  (l_in[4]),
    .E1H_sorter_out0  (h_in[0]),
    .E1H_sorter_out1  (h_in[1]),
    .E1H_sorter_out2  (h_in[2]),
    .E1H_sorter_out3  (h_in[3]),
    .E1H_sorter_out4  (h_in[4]),
    .E1_sort_en       (en),
    .E1_last_sort     (last),
    .E1_index_counter (counter),
    .topk_out0        (out[0]),
    .topk_out1        (out[1]),
    .topk_out2        (out[2]),
    .topk_out3        (out[3]),
    .topk_out4        (out[4]),
    .topk_cnt         (topk_cnt),
    .topk_valid       (topk_valid),
    .busy             (busy),
    .overflow         (overflow)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [IN_W-1:0] mk(input int lane, input int score);
    return {16'(lane), 8'(score)};
  endfunction

  function automatic logic [31:0] ent(input int gidx, input int score);
    return 32'({21'(gidx), 8'(score)});
  endfunction

  task automatic clear_inputs();
    for (int i = 0; i < 5; i++) begin
      l_in[i] = mk(0, 128);
      h_in[i] = mk(0, 128);
    end
  endtask

  task automatic load_basic();
    clear_inputs();
    for (int i = 0; i < 5; i++) begin
      l_in[i] = mk(i, 50 - 10 * i);
      h_in[i] = mk(16 + i, 45 - 10 * i);
    end
  endtask

  // Called at a falling edge; the batch is captured on the following rising edge.
  task automatic send(input bit lst, input int cntr);
    en      = 1'b1;
    last    = lst;
    counter = 16'(cntr);
    @(negedge sys_clk);
    en      = 1'b0;
    last    = 1'b0;
  endtask

  task automatic run(input int n);
    repeat (n) begin
      @(negedge sys_clk);
      if (busy) busy_seen = 1'b1;
      if (topk_valid) begin
        vcount++;
        for (int i = 0; i < 5; i++) snap[i] = out[i];
        snapcnt = topk_cnt;
      end
    end
  endtask

  initial begin
    sys_rst    = 1'b1;
    sorter_clr = 1'b0;
    en         = 1'b0;
    last       = 1'b0;
    counter    = 16'd0;
    clear_inputs();
    repeat (2) @(negedge sys_clk);
    chk("rst_out0", 32'(out[0]), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    sys_rst = 1'b0;
    @(negedge sys_clk);
    chk("post_rst_cnt", 32'(topk_cnt), 32'd0);
    chk("post_rst_valid", 32'(topk_valid), 32'd0);
    chk("post_rst_ovf", 32'(overflow), 32'd0);

    // Single batch, exact EMIT timing.
    load_basic();
    send(1'b1, 1);
    @(negedge sys_clk);
    chk("t1_busy", 32'(busy), 32'd1);
    repeat (9) @(negedge sys_clk);
    chk("t1_valid_early", 32'(topk_valid), 32'd0);
    @(negedge sys_clk);
    chk("t1_valid", 32'(topk_valid), 32'd1);
    chk("t1_out0", 32'(out[0]), ent(0, 50));
    chk("t1_out1", 32'(out[1]), ent(16, 45));
    chk("t1_out2", 32'(out[2]), ent(1, 40));
    chk("t1_out3", 32'(out[3]), ent(17, 35));
    chk("t1_out4", 32'(out[4]), ent(2, 30));
    chk("t1_cnt", 32'(topk_cnt), 32'd5);
    @(negedge sys_clk);
    chk("t1_valid_off", 32'(topk_valid), 32'd0);
    chk("t1_cleared_cnt", 32'(topk_cnt), 32'd0);
    chk("t1_cleared_out0", 32'(out[0]), 32'd0);
    chk("t1_idle", 32'(busy), 32'd0);

    // Two lines of one frame.
    clear_inputs();
    for (int i = 0; i < 5; i++) l_in[i] = mk(i, 10 - i);
    vcount = 0;
    send(1'b0, 1);
    run(12);
    chk("t2_mid_busy", 32'(busy), 32'd0);
    chk("t2_mid_cnt", 32'(topk_cnt), 32'd5);
    clear_inputs();
    l_in[0] = mk(3, 100);
    send(1'b1, 2);
    run(13);
    chk("t2_pulses", 32'(vcount), 32'd1);
    chk("t2_out0", 32'(snap[0]), ent(35, 100));
    chk("t2_out1", 32'(snap[1]), ent(0, 10));
    chk("t2_out4", 32'(snap[4]), ent(3, 7));
    chk("t2_cnt", 32'(snapcnt), 32'd5);

    // Padding skipped, equal scores keep arrival order.
    clear_inputs();
    l_in[2] = mk(2, -5);
    h_in[2] = mk(18, -5);
    vcount = 0;
    send(1'b1, 1);
    run(13);
    chk("t3_pulses", 32'(vcount), 32'd1);
    chk("t3_cnt", 32'(snapcnt), 32'd2);
    chk("t3_out0", 32'(snap[0]), ent(2, -5));
    chk("t3_out1", 32'(snap[1]), ent(18, -5));
    chk("t3_out2", 32'(snap[2]), 32'd0);
    chk("t3_out3", 32'(snap[3]), 32'd0);
    chk("t3_out4", 32'(snap[4]), 32'd0);

    // Three back-to-back strobes: third is dropped.
    clear_inputs();
    l_in[0] = mk(0, 20);
    en = 1'b1; last = 1'b0; counter = 16'd1;
    @(negedge sys_clk);
    l_in[0] = mk(1, 30); last = 1'b1; counter = 16'd2;
    @(negedge sys_clk);
    l_in[0] = mk(2, 90); counter = 16'd3;
    @(negedge sys_clk);
    en = 1'b0; last = 1'b0;
    chk("t4_ovf_set", 32'(overflow), 32'd1);
    vcount = 0;
    run(25);
    chk("t4_pulses", 32'(vcount), 32'd1);
    chk("t4_out0", 32'(snap[0]), ent(33, 30));
    chk("t4_out1", 32'(snap[1]), ent(0, 20));
    chk("t4_cnt", 32'(snapcnt), 32'd2);
    chk("t4_ovf_sticky", 32'(overflow), 32'd1);
    sorter_clr = 1'b1;
    @(negedge sys_clk);
    sorter_clr = 1'b0;
    chk("t4_ovf_clr", 32'(overflow), 32'd0);

    // Asynchronous reset in the middle of a merge.
    load_basic();
    send(1'b1, 1);
    repeat (5) @(negedge sys_clk);
    chk("t5_busy_pre", 32'(busy), 32'd1);
    chk("t5_cnt_pre", 32'(topk_cnt), 32'd4);
    #2 sys_rst = 1'b1;
    #1;
    chk("t5_async_out0", 32'(out[0]), 32'd0);
    chk("t5_async_cnt", 32'(topk_cnt), 32'd0);
    chk("t5_async_busy", 32'(busy), 32'd0);
    chk("t5_async_valid", 32'(topk_valid), 32'd0);
    @(negedge sys_clk);
    @(negedge sys_clk);
    sys_rst = 1'b0;
    load_basic();
    vcount = 0;
    send(1'b1, 3);
    run(13);
    chk("t5_pulses", 32'(vcount), 32'd1);
    chk("t5_out0", 32'(snap[0]), ent(64, 50));
    chk("t5_out1", 32'(snap[1]), ent(80, 45));
    chk("t5_cnt", 32'(snapcnt), 32'd5);

    // Clear coincident with a strobe discards the batch.
    clear_inputs();
    l_in[0] = mk(0, 77);
    sorter_clr = 1'b1;
    send(1'b1, 1);
    sorter_clr = 1'b0;
    chk("t6_busy", 32'(busy), 32'd0);
    vcount    = 0;
    busy_seen = 1'b0;
    run(13);
    chk("t6_pulses", 32'(vcount), 32'd0);
    chk("t6_busy_seen", 32'(busy_seen), 32'd0);
    chk("t6_cnt", 32'(topk_cnt), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/sort_e2_merge.md
SORT_E2_MERGE -- requirements
Module: sort_e2_merge

Interface
REQ-001 SHALL have parameter Data_Width, default 8: signed score width.
REQ-002 SHALL have parameter Index_Width, default 16: line counter width.
REQ-003 SHALL have parameter Lane_Bits, default 5: local lane index bits (32 lanes per line).
REQ-004 SHALL have port sys_clk  in  1: the single clock; all state is updated on its rising edge.
REQ-005 SHALL have port sys_rst  in  1: asynchronous, active-high reset.
REQ-006 SHALL have port sorter_clr  in  1: synchronous clear.
REQ-007 SHALL have ports E1L_sorter_out0..4 and E1H_sorter_out0..4  in  Index_Width+Data_Width each: {local idx, score}, each list already descending.
REQ-008 SHALL have port E1_sort_en  in  1: one-cycle pulse; the ten E1 inputs are valid in that cycle.
REQ-009 SHALL have port E1_last_sort  in  1: qualifies E1_sort_en; marks the final line of a frame.
REQ-010 SHALL have port E1_index_counter  in  Index_Width: line count, 1-based.
REQ-011 SHALL have ports topk_out0..4  out  Index_Width+Lane_Bits+Data_Width each: {global idx, score}, descending.
REQ-012 SHALL have port topk_cnt  out  3: number of valid topk entries, 0..5.
REQ-013 SHALL have port topk_valid  out  1: one-cycle pulse; the frame result is final.
REQ-014 SHALL have port busy  out  1: high while the merge FSM is not IDLE.
REQ-015 SHALL have port overflow  out  1: sticky; set when a batch is dropped.

Function
REQ-016 SHALL capture all ten inputs into a pending buffer on the rising edge where E1_sort_en=1, together with E1_last_sort and line = E1_index_counter-1 (mod 2^Index_Width).
REQ-017 SHALL form global idx as {line, local_idx[Lane_Bits-1:0]}; upper local idx bits are ignored.
REQ-018 SHALL implement FSM states IDLE, MERGE and EMIT: IDLE->MERGE when the pending buffer is full; MERGE lasts exactly 10 cycles (cnt 0..9); after cnt=9 -> EMIT if the batch last flag=1, otherwise IDLE, or MERGE directly if the pending buffer is full; EMIT->IDLE (or MERGE if pending) after 1 cycle.
REQ-019 SHALL move the pending buffer to the working buffer on MERGE entry, freeing pending the same cycle, so one further batch is accepted during MERGE.
REQ-020 SHALL, per MERGE cycle, insert one candidate in order L0,H0,L1,H1,...,L4,H4 into the 5-entry running list using a signed score compare.
REQ-021 SHALL place a candidate ahead of an entry only if its score is strictly greater; ties keep the existing entry first; entries below the insertion point shift down and entry 4 is discarded.
REQ-022 SHALL skip a candidate whose score equals 8'h80 (padding): no insertion, the cycle is still consumed.
REQ-023 SHALL insert into an empty slot (slot index >= topk_cnt) unconditionally and increment topk_cnt, saturating at 5.
REQ-024 SHALL drive topk_out0..4 and topk_cnt directly from the running list at all times; invalid slots read 0.
REQ-025 SHALL assert topk_valid for exactly the EMIT cycle, 11 cycles after the capturing edge when the FSM is idle (capture at edge t, MERGE t+1..t+10, EMIT t+11), and then clear the running list and topk_cnt on the edge leaving EMIT.
REQ-026 SHALL, when E1_sort_en=1 while the pending buffer is full, drop the new batch, set overflow and leave merge state untouched.
REQ-027 SHALL, when pending is freed and E1_sort_en=1 on the same edge, accept the new batch (no overflow).
REQ-028 SHALL give sorter_clr priority over all function: it clears the list, topk_cnt, buffers and overflow, sets the FSM to IDLE, forces topk_valid=0 and ignores a coincident E1_sort_en.

Reset
REQ-029 SHALL, while sys_rst=1 at any time (including mid-MERGE), asynchronously force: all topk_out=0, topk_cnt=0, topk_valid=0, busy=0, overflow=0, FSM=IDLE, buffers empty, counters 0.
REQ-030 SHALL resume normal capture on the first rising edge after sys_rst deasserts.

Verification
REQ-031 Single-batch test: with last=1, counter=1, L scores 50,40,30,20,10 at lanes 0..4 and H scores 45,35,25,15,5 at lanes 16..20 -> topk_valid at t+11 with scores 50,45,40,35,30, idx 0,16,1,17,2, and topk_cnt=5.
REQ-032 Multi-line test: batch 1 (counter=1) has max score 10; batch 2 (counter=2, last=1) has L0 score 100 at lane 3 -> out0={idx 35, score 100}, and exactly one topk_valid pulse.
REQ-033 Padding/tie test: only two non-0x80 candidates, both score -5 (L lane 2, H lane 18), last=1 -> topk_cnt=2, out0 idx 2, out1 idx 18, out2..4=0.
REQ-034 Overflow test: three E1_sort_en pulses on consecutive cycles -> first two are merged, third is dropped, overflow=1 until sorter_clr.
REQ-035 Reset test: assert sys_rst at MERGE cnt=4 -> all outputs 0 immediately, without waiting for a clock edge; a new batch after release produces a correct result.
REQ-036 Clear test: sorter_clr asserted coincident with E1_sort_en -> FSM stays IDLE, busy=0, no topk_valid follows.
